// File: rtl/dac_out_if.sv
// Input-side handshake bundle for dac_out: enable gate plus the VALID/READY data channel.
interface dac_out_if #(
    parameter int FLOAT_WIDTH = 64
) ();
    logic                   enable;
    logic [FLOAT_WIDTH-1:0] DATA_IN;
    logic                   IN_VALID;
    logic                   IN_READY;

    modport master (output enable, output DATA_IN, output IN_VALID, input IN_READY);
    modport slave  (input enable, input DATA_IN, input IN_VALID, output IN_READY);
endinterface

// File: rtl/dac_out.sv
// dac_out: takes one signed 16Q48 actuator value per handshake, scales it to an unsigned
// DAC code with round-half-up, clamps it, strobes it to the DAC and pulses DONE once the
// programmable settle time has elapsed.
module dac_out #(
    parameter int unsigned          FLOAT_WIDTH   = 64,
    parameter int unsigned          DAC_WIDTH     = 12,
    parameter logic [31:0]          CODE_SCALE    = 32'h0066_6666,
    parameter int unsigned          MUL_LAT       = 2,
    parameter int unsigned          SETTLE_CYCLES = 64,
    parameter logic [DAC_WIDTH-1:0] RESET_CODE    = '0
) (
    input  logic                 DAC_CLK,
    input  logic                 RST_N,
    dac_out_if.slave             in_bus,
    output logic [DAC_WIDTH-1:0] DAC_DATA_OUT,
    output logic                 DAC_WR,
    output logic                 DONE,
    output logic                 SAT
);

    localparam int unsigned PROD_WIDTH  = FLOAT_WIDTH + 33;
    localparam logic [31:0] MUL_LAST    = 32'(MUL_LAT - 1);
    localparam logic [31:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 32'd0 : 32'(SETTLE_CYCLES - 1);

    // 0.5 LSB of the output code in product units, and the largest legal DAC code.
    localparam logic signed [PROD_WIDTH-1:0] HALF_LSB = PROD_WIDTH'(1) <<< 63;
    localparam logic signed [PROD_WIDTH-1:0] CODE_MAX = (PROD_WIDTH'(1) <<< DAC_WIDTH) - PROD_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        CLAMP,
        WRITE,
        SETTLE,
        FIN
    } state_t;

    state_t state, state_next;
    logic [31:0] cnt;

    logic                         accept;
    logic [FLOAT_WIDTH-1:0]       data_q;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [PROD_WIDTH-1:0] mul_pipe [MUL_LAT];
    logic signed [PROD_WIDTH-1:0] rounded;
    logic                         sat_lo, sat_hi;
    logic [DAC_WIDTH-1:0]         code_next;

    assign accept = (state == IDLE) && in_bus.IN_VALID && in_bus.IN_READY;

    // Unsigned scale is zero-extended so the whole multiply stays signed.
    assign product = $signed(data_q) * $signed({1'b0, CODE_SCALE});

    // Round half up, then floor via arithmetic shift; the full width is kept for the range test.
    assign rounded   = (mul_pipe[MUL_LAT-1] + HALF_LSB) >>> 64;
    assign sat_lo    = rounded < 0;
    assign sat_hi    = rounded > CODE_MAX;
    assign code_next = sat_lo ? '0 : (sat_hi ? '1 : rounded[DAC_WIDTH-1:0]);

    // State register and the shared MUL/SETTLE cycle counter.
    always_ff @(posedge DAC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + 32'd1;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves a latch.
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = MUL;
            MUL:     if (cnt == MUL_LAST) state_next = CLAMP;
            CLAMP:   state_next = WRITE;
            WRITE:   state_next = (SETTLE_CYCLES == 0) ? FIN : SETTLE;
            SETTLE:  if (cnt == SETTLE_LAST) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs; READY is additionally gated by enable and held low while in reset.
    always_comb begin
        in_bus.IN_READY = 1'b0;
        DAC_WR          = 1'b0;
        DONE            = 1'b0;
        case (state)
            IDLE:    in_bus.IN_READY = in_bus.enable & RST_N;
            WRITE:   DAC_WR = 1'b1;
            FIN:     DONE = 1'b1;
            default: ;
        endcase
    end

    // Input capture and multiplier pipeline.
    always_ff @(posedge DAC_CLK) begin
        // NOTE: pure datapath with no reset; its contents are only consumed after a handshake refills it.
        if (accept) data_q <= in_bus.DATA_IN;
        mul_pipe[0] <= product;
        for (int i = 1; i < int'(MUL_LAT); i++) mul_pipe[i] <= mul_pipe[i-1];
    end

    // DAC code and saturation flag update on the edge that enters WRITE and hold otherwise.
    always_ff @(posedge DAC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            DAC_DATA_OUT <= RESET_CODE;
            SAT          <= 1'b0;
        end else if (state == CLAMP) begin
            DAC_DATA_OUT <= code_next;
            SAT          <= sat_lo | sat_hi;
        end
    end

endmodule
